// File: rtl/sprite_pkg.sv
// Shared constants, colour codes and FSM encoding for the sprite plotter.
// Field positions describe the packed {x, y, colour} sprite word.
package sprite_pkg;

  localparam int POS_X_MSB = 17;
  localparam int POS_X_LSB = 10;
  localparam int POS_Y_MSB = 9;
  localparam int POS_Y_LSB = 3;
  localparam int COL_MSB   = 2;
  localparam int COL_LSB   = 0;

  localparam logic [2:0] COL_ERASE   = 3'b000;
  localparam logic [2:0] COL_PLAYER  = 3'b001;
  localparam logic [2:0] COL_BOULDER = 3'b100;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } plot_state_t;

  function automatic logic on_screen(input logic [8:0] xs, input logic [7:0] ys,
                                     input logic [8:0] xmax, input logic [7:0] ymax);
    return (xs <= xmax) && (ys <= ymax);
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major cx/cy scan over a SPRITE_W x SPRITE_H block with synchronous clear,
// step enable, and a flag marking the final pixel of the block.
module sprite_scan_counter #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] cx,
  output logic [3:0] cy,
  output logic       last
);

  localparam logic [3:0] CX_LAST = 4'(SPRITE_W - 1);
  localparam logic [3:0] CY_LAST = 4'(SPRITE_H - 1);

  logic row_end;

  assign row_end = (cx == CX_LAST);
  assign last    = row_end && (cy == CY_LAST);

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      cx <= 4'd0;
      cy <= 4'd0;
    end else if (clear) begin
      cx <= 4'd0;
      cy <= 4'd0;
    end else if (enable) begin
      if (row_end) begin
        cx <= 4'd0;
        // the final pixel also rewinds cy so the counter idles at the origin
        cy <= last ? 4'd0 : cy + 4'd1;
      end else begin
        cx <= cx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Rasterises a sprite block one pixel per clock onto the VGA x/y/colour/plot port.
// Optional SPRITE_PLOTTER_CLIP_EN suppresses plot for pixels beyond X_MAX/Y_MAX.
module sprite_plotter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int X_MAX    = SCREEN_W - 1,
  parameter int Y_MAX    = SCREEN_H - 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [17:0] pos_in,
  input  logic        draw_go,
  output logic        draw_busy,
  output logic        draw_done,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  plot_state_t state, state_next;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] base_col;
  logic [3:0] cx, cy;
  logic       last;
  logic       accept;
  logic       drawing;
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       pix_vis;

  // Outputs lag the state by one register; gating on draw_busy keeps the
  // draw_done cycle closed to new requests as well.
  assign accept  = draw_go && (state == ST_IDLE) && !draw_busy;
  assign drawing = (state == ST_DRAW);

  assign x_sum = {1'b0, base_x} + {5'd0, cx};
  assign y_sum = {1'b0, base_y} + {4'd0, cy};

`ifdef SPRITE_PLOTTER_CLIP_EN
  assign pix_vis = on_screen(x_sum, y_sum, 9'(X_MAX), 8'(Y_MAX));
`else
  logic clip_unused;
  assign clip_unused = on_screen(x_sum, y_sum, 9'(X_MAX), 8'(Y_MAX));
  assign pix_vis     = 1'b1;
`endif

  sprite_scan_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clear  (accept),
    .enable (drawing),
    .cx     (cx),
    .cy     (cy),
    .last   (last)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_DRAW;
      ST_DRAW: if (last)   state_next = ST_DONE;
      ST_DONE:             state_next = ST_IDLE;
      default:             state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      base_x   <= 8'd0;
      base_y   <= 7'd0;
      base_col <= 3'd0;
    end else if (accept) begin
      base_x   <= pos_in[POS_X_MSB:POS_X_LSB];
      base_y   <= pos_in[POS_Y_MSB:POS_Y_LSB];
      base_col <= pos_in[COL_MSB:COL_LSB];
    end
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
      draw_busy  <= 1'b0;
      draw_done  <= 1'b0;
    end else begin
      vga_x      <= drawing ? x_sum[7:0] : 8'd0;
      vga_y      <= drawing ? y_sum[6:0] : 7'd0;
      vga_colour <= drawing ? base_col : 3'd0;
      vga_plot   <= drawing && pix_vis;
      draw_busy  <= (state != ST_IDLE);
      draw_done  <= (state == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: scoreboard of expected pixels, cycle-exact
// checks of busy/done, busy-ignore, mid-sprite reset and wrap/clip behaviour.
module tb_sprite_plotter;

  logic        clock;
  logic        resetn;
  logic [17:0] pos_in;
  logic        draw_go;
  logic        draw_busy;
  logic        draw_done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int total = 0;
  int bad   = 0;

  // {plot, x, y, colour}
  logic [18:0] exp_q[$];

  sprite_plotter dut (
    .clock      (clock),
    .resetn     (resetn),
    .pos_in     (pos_in),
    .draw_go    (draw_go),
    .draw_busy  (draw_busy),
    .draw_done  (draw_done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_model(input logic [17:0] pos);
    logic [8:0] xs;
    logic [7:0] ys;
    logic       p;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        xs = {1'b0, pos[17:10]} + 9'(c);
        ys = {1'b0, pos[9:3]} + 8'(r);
`ifdef SPRITE_PLOTTER_CLIP_EN
        p = (xs <= 9'd159) && (ys <= 8'd119);
`else
        p = 1'b1;
`endif
        exp_q.push_back({p, xs[7:0], ys[6:0], pos[2:0]});
      end
    end
  endtask

  task automatic run_sprite(input logic [17:0] pos, input bit inj, input int abort_at,
                            input logic [17:0] alt);
    logic [18:0] e;
    push_model(pos);
    pos_in  = pos;
    draw_go = 1'b1;
    @(posedge clock); #1;
    draw_go = 1'b0;
    pos_in  = alt;
    check("accept_cycle_plot", 32'(vga_plot), 32'd0);
    check("accept_cycle_busy", 32'(draw_busy), 32'd0);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clock); #1;
      if (k <= 16) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", 32'({vga_plot, vga_x, vga_y, vga_colour}), 32'(e));
        end
        check("busy_in_draw", 32'(draw_busy), 32'd1);
        check("done_in_draw", 32'(draw_done), 32'd0);
      end else if (k == 17) begin
        check("done_pulse", 32'(draw_done), 32'd1);
        check("done_plot", 32'(vga_plot), 32'd0);
        check("done_busy", 32'(draw_busy), 32'd1);
      end else begin
        check("done_cleared", 32'(draw_done), 32'd0);
        check("busy_cleared", 32'(draw_busy), 32'd0);
      end
      if (k == abort_at) begin
        resetn = 1'b1;
        #1;
        check("rst_outputs", 32'({vga_plot, vga_x, vga_y, vga_colour, draw_busy, draw_done}), 32'd0);
        exp_q.delete();
        for (int j = 0; j < 3; j++) begin
          @(posedge clock); #1;
          check("rst_no_done", 32'(draw_done), 32'd0);
        end
        resetn = 1'b0;
        for (int j = 0; j < 2; j++) begin
          @(posedge clock); #1;
          check("rst_idle", 32'({draw_busy, draw_done, vga_plot}), 32'd0);
        end
        return;
      end
      if (inj) begin
        draw_go = (k == 5) || (k == 17);
      end
    end
    draw_go = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(posedge clock); #1;
      check("idle_after", 32'({draw_busy, vga_plot, draw_done}), 32'd0);
    end
  endtask

  initial begin
    resetn  = 1'b1;
    pos_in  = 18'd0;
    draw_go = 1'b0;
    #12;
    check("reset_state", 32'({vga_plot, vga_x, vga_y, vga_colour, draw_busy, draw_done}), 32'd0);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock); #1;
    check("post_reset_idle", 32'({draw_busy, vga_plot}), 32'd0);

    // basic draw, colour player
    run_sprite({8'd10, 7'd20, 3'b001}, 1'b0, 0, {8'd99, 7'd99, 3'b111});
    // right edge: columns 160/161 wrap-free in 9 bits, clipped when enabled
    run_sprite({8'd158, 7'd0, 3'b100}, 1'b0, 0, 18'd0);
    // bottom rows wrap through 127 -> 0
    run_sprite({8'd0, 7'd126, 3'b010}, 1'b0, 0, 18'd0);
    // right-most column wraps modulo 256
    run_sprite({8'd254, 7'd5, 3'b011}, 1'b0, 0, 18'd0);
    // requests during DRAW and during the done cycle are ignored
    run_sprite({8'd30, 7'd40, 3'b101}, 1'b1, 0, {8'd77, 7'd11, 3'b110});
    // reset after five pixels, then a full sprite at a new base
    run_sprite({8'd50, 7'd50, 3'b001}, 1'b0, 5, 18'd0);
    run_sprite({8'd60, 7'd70, 3'b100}, 1'b0, 0, 18'd0);
    // erase pass
    run_sprite({8'd40, 7'd60, 3'b000}, 1'b0, 0, 18'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
